// File: rtl/war_pkg.sv
// Shared encodings for the War game deck-RAM request interface.
// Holds op codes, list ids, card field positions and the node-to-card mapping.
package war_pkg;

  localparam logic [1:0] OP_INIT  = 2'd0;
  localparam logic [1:0] OP_PEEK  = 2'd1;
  localparam logic [1:0] OP_MOVE  = 2'd2;
  localparam logic [1:0] OP_COUNT = 2'd3;

  localparam logic [1:0] LIST_DECK   = 2'd0;
  localparam logic [1:0] LIST_PLAYER = 2'd1;
  localparam logic [1:0] LIST_COM    = 2'd2;
  localparam logic [1:0] LIST_POT    = 2'd3;

  localparam int RANK_LSB = 0;
  localparam int RANK_W   = 4;
  localparam int SUIT_LSB = 4;
  localparam int SUIT_W   = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT_WR,
    S_EXEC,
    S_MV_RD,
    S_MV_UPD,
    S_DONE
  } state_t;

  // Rank runs 2..14 (ace high) within each block of 13 nodes; suit is the block number.
  function automatic logic [15:0] card_of(input logic [5:0] node);
    logic [15:0] c;
    c = '0;
    c[RANK_LSB +: RANK_W] = 4'(node % 6'd13 + 6'd2);
    c[SUIT_LSB +: SUIT_W] = 2'(node / 6'd13);
    return c;
  endfunction

endpackage

// File: rtl/card_list_server_if.sv
// Request/response bundle between the War game controller and the card list server.
interface card_list_server_if;
  logic        enable;
  logic [1:0]  select_op;
  logic [9:0]  arg1;
  logic [9:0]  arg2;
  logic        finished_op;
  logic [15:0] out1;
  logic        op_error;

  modport master (
    output enable, select_op, arg1, arg2,
    input  finished_op, out1, op_error
  );

  modport slave (
    input  enable, select_op, arg1, arg2,
    output finished_op, out1, op_error
  );
endinterface

// File: rtl/next_ptr_ram.sv
// Next-pointer storage for the card lists: one write port, one registered read port.
module next_ptr_ram #(
  parameter int AW = 6
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [AW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [AW-1:0] o_rdata
);

  logic [AW-1:0] r_mem [2**AW];
  logic [AW-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/card_list_server.sv
// Executes INIT/PEEK/MOVE/COUNT requests on four singly-linked card lists kept
// in a next-pointer RAM; each request ends with a one-cycle finished_op pulse.
module card_list_server
  import war_pkg::*;
#(
  parameter int DECK_SIZE = 52,
  parameter int NODE_AW   = 6,
  parameter int NUM_LISTS = 4
) (
  input  logic               clock,
  input  logic               reset,
  card_list_server_if.slave  bus
);

  localparam int LW = $clog2(NUM_LISTS);
  localparam int CW = 7;

  state_t              r_state, w_state_nxt;
  logic [1:0]          r_op;
  logic [LW-1:0]       r_src, r_dst;
  logic [CW-1:0]       r_idx;
  logic [NODE_AW-1:0]  r_head [NUM_LISTS];
  logic [NODE_AW-1:0]  r_tail [NUM_LISTS];
  logic [CW-1:0]       r_cnt  [NUM_LISTS];
  logic [15:0]         r_out1;
  logic                r_err;

  logic                w_we;
  logic [NODE_AW-1:0]  w_waddr, w_wdata, w_rdata, w_n;
  logic                w_src_empty, w_dst_empty, w_self, w_src_single, w_init_last;
  logic                w_unused_args;

  assign w_n          = r_head[r_src];
  assign w_src_empty  = (r_cnt[r_src] == '0);
  assign w_dst_empty  = (r_cnt[r_dst] == '0);
  assign w_src_single = (r_cnt[r_src] == CW'(1));
  assign w_self       = (r_src == r_dst);
  assign w_init_last  = (r_idx == CW'(DECK_SIZE));
  assign w_unused_args = &{bus.arg1[9:LW], bus.arg2[9:LW]};

  next_ptr_ram #(.AW(NODE_AW)) u_ram (
    .i_clk   (clock),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_n),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_we        = 1'b0;
    w_waddr     = r_tail[r_dst];
    w_wdata     = w_n;
    unique case (r_state)
      S_IDLE: begin
        if (bus.enable) begin
          case (bus.select_op)
            OP_INIT: w_state_nxt = S_INIT_WR;
            OP_MOVE: w_state_nxt = S_MV_RD;
            default: w_state_nxt = S_EXEC;
          endcase
        end
      end
      // One idle cycle after the last write lines DONE up with the INIT latency.
      S_INIT_WR: begin
        if (w_init_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_we    = 1'b1;
          w_waddr = r_idx[NODE_AW-1:0];
          w_wdata = r_idx[NODE_AW-1:0] + NODE_AW'(1);
        end
      end
      S_EXEC:   w_state_nxt = S_DONE;
      S_MV_RD:  w_state_nxt = w_src_empty ? S_DONE : S_MV_UPD;
      S_MV_UPD: begin
        w_state_nxt = S_DONE;
        w_we        = !w_dst_empty && !(w_self && w_src_single);
      end
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int l = 0; l < NUM_LISTS; l++) begin
        r_head[l] <= '0;
        r_tail[l] <= '0;
        r_cnt[l]  <= '0;
      end
      r_op   <= OP_INIT;
      r_src  <= '0;
      r_dst  <= '0;
      r_idx  <= '0;
      r_out1 <= '0;
      r_err  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.enable) begin
            r_op  <= bus.select_op;
            r_src <= bus.arg1[LW-1:0];
            r_dst <= bus.arg2[LW-1:0];
            r_idx <= '0;
          end
        end
        S_INIT_WR: begin
          r_idx <= r_idx + CW'(1);
          if (w_init_last) begin
            for (int l = 0; l < NUM_LISTS; l++) r_cnt[l] <= '0;
            r_head[LIST_DECK] <= '0;
            r_tail[LIST_DECK] <= NODE_AW'(DECK_SIZE - 1);
            r_cnt[LIST_DECK]  <= CW'(DECK_SIZE);
            r_out1 <= 16'(DECK_SIZE);
            r_err  <= 1'b0;
          end
        end
        S_EXEC: begin
          if (r_op == OP_PEEK) begin
            r_out1 <= w_src_empty ? 16'd0 : card_of(6'(w_n));
            r_err  <= w_src_empty;
          end else begin
            r_out1 <= 16'(r_cnt[r_src]);
            r_err  <= 1'b0;
          end
        end
        S_MV_RD: begin
          if (w_src_empty) begin
            r_out1 <= '0;
            r_err  <= 1'b1;
          end
        end
        // Rotation is handled separately so head/tail/count stay coherent on one list.
        S_MV_UPD: begin
          r_out1 <= card_of(6'(w_n));
          r_err  <= 1'b0;
          if (w_self) begin
            if (!w_src_single) begin
              r_head[r_src] <= w_rdata;
              r_tail[r_src] <= w_n;
            end
          end else begin
            r_head[r_src] <= w_rdata;
            r_cnt[r_src]  <= r_cnt[r_src] - CW'(1);
            r_tail[r_dst] <= w_n;
            if (w_dst_empty) r_head[r_dst] <= w_n;
            r_cnt[r_dst]  <= r_cnt[r_dst] + CW'(1);
          end
        end
        S_DONE:  r_err <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.finished_op = (r_state == S_DONE);
  assign bus.out1        = r_out1;
  assign bus.op_error    = r_err;

endmodule

// File: tb/tb_card_list_server.sv
// Bench for card_list_server: directed vector table, held-enable and mid-INIT reset
// sequences, then random requests checked against a queue-based list model.
module tb_card_list_server;
  import war_pkg::*;

  localparam int DECK = 52;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  card_list_server_if bus();

  card_list_server #(.DECK_SIZE(DECK), .NODE_AW(6), .NUM_LISTS(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int op;
    int a1;
    int a2;
    int xo;
    int xe;
    int xl;
  } vec_t;

  int   n_vec = 0;
  int   n_bad = 0;
  int   lq [4][$];
  vec_t tbl [19];

  function automatic int ref_card(input int n);
    return (n % 13 + 2) + ((n / 13) % 4) * 16;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int l = 0; l < 4; l++) lq[l].delete();
  endtask

  task automatic model(input int op, input int a1, input int a2,
                       output int eo, output int ee, output int el);
    int s, d, n;
    s = a1 % 4; d = a2 % 4;
    eo = 0; ee = 0; el = 1;
    case (op)
      0: begin
        model_clear();
        for (int i = 0; i < DECK; i++) lq[0].push_back(i);
        eo = DECK; el = DECK + 1;
      end
      1: if (lq[s].size() == 0) ee = 1; else eo = ref_card(lq[s][0]);
      2: if (lq[s].size() == 0) ee = 1;
         else begin
           n = lq[s].pop_front();
           lq[d].push_back(n);
           eo = ref_card(n);
           el = 2;
         end
      default: eo = lq[s].size();
    endcase
  endtask

  task automatic issue(input int op, input int a1, input int a2);
    @(negedge clock);
    bus.enable    = 1'b1;
    bus.select_op = 2'(op);
    bus.arg1      = 10'(a1);
    bus.arg2      = 10'(a2);
    @(posedge clock);
    #1;
    bus.enable = 1'b0;
  endtask

  task automatic wait_fin(output int edges);
    edges = -1;
    for (int e = 1; e <= 200; e++) begin
      @(posedge clock);
      #1;
      if (bus.finished_op) begin
        edges = e;
        return;
      end
    end
  endtask

  task automatic run_op(input string name, input int op, input int a1, input int a2,
                        input int xo, input int xe, input int xl);
    int e;
    issue(op, a1, a2);
    wait_fin(e);
    check({name, " latency"}, e, xl);
    if (e > 0) begin
      check({name, " out1"}, int'(bus.out1), xo);
      check({name, " op_error"}, int'(bus.op_error), xe);
      @(posedge clock);
      #1;
      check({name, " pulse end"}, int'(bus.finished_op), 0);
      check({name, " error clear"}, int'(bus.op_error), 0);
    end
  endtask

  task automatic apply_vec(input int i);
    int eo, ee, el;
    model(tbl[i].op, tbl[i].a1, tbl[i].a2, eo, ee, el);
    run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a1, tbl[i].a2,
           tbl[i].xo, tbl[i].xe, tbl[i].xl);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e, eo, ee, el, seen, op, a1, a2;

    tbl[0]  = '{3, 0, 0, 0, 0, 1};
    tbl[1]  = '{0, 0, 0, 52, 0, 53};
    tbl[2]  = '{3, 0, 0, 52, 0, 1};
    tbl[3]  = '{1, 0, 0, 16'h0002, 0, 1};
    tbl[4]  = '{3, 1, 0, 3, 0, 1};
    tbl[5]  = '{3, 0, 0, 49, 0, 1};
    tbl[6]  = '{1, 1, 0, 16'h0002, 0, 1};
    tbl[7]  = '{2, 2, 3, 0, 1, 1};
    tbl[8]  = '{3, 10'h3FC, 0, 49, 0, 1};
    tbl[9]  = '{3, 10'h3FD, 0, 3, 0, 1};
    tbl[10] = '{3, 2, 0, 0, 0, 1};
    tbl[11] = '{3, 3, 0, 0, 0, 1};
    tbl[12] = '{2, 1, 1, 16'h0002, 0, 2};
    tbl[13] = '{1, 1, 0, 16'h0003, 0, 1};
    tbl[14] = '{2, 1, 1, 16'h0003, 0, 2};
    tbl[15] = '{2, 1, 1, 16'h0004, 0, 2};
    tbl[16] = '{2, 1, 1, 16'h0002, 0, 2};
    tbl[17] = '{1, 1, 0, 16'h0003, 0, 1};
    tbl[18] = '{3, 1, 0, 3, 0, 1};

    bus.enable = 1'b0; bus.select_op = '0; bus.arg1 = '0; bus.arg2 = '0;
    reset = 1'b1;
    model_clear();
    repeat (3) @(posedge clock);
    #1;
    check("reset finished_op", int'(bus.finished_op), 0);
    check("reset out1", int'(bus.out1), 0);
    check("reset op_error", int'(bus.op_error), 0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 4; i++) apply_vec(i);

    // Three MOVE(0->1) requests back to back with enable held high.
    @(negedge clock);
    bus.enable = 1'b1; bus.select_op = 2'd2; bus.arg1 = 10'd0; bus.arg2 = 10'd1;
    @(posedge clock);
    #1;
    for (int j = 0; j < 3; j++) begin
      model(2, 0, 1, eo, ee, el);
      wait_fin(e);
      check($sformatf("held move%0d spacing", j), e, (j == 0) ? 2 : 4);
      check($sformatf("held move%0d out1", j), int'(bus.out1), eo);
      if (e < 0) break;
    end
    bus.enable = 1'b0;
    @(posedge clock);
    #1;
    check("held pulse end", int'(bus.finished_op), 0);

    for (int i = 4; i < 19; i++) apply_vec(i);

    // Reset during the 20th INIT_WR cycle must abort with no completion.
    issue(0, 0, 0);
    repeat (19) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("mid reset out1", int'(bus.out1), 0);
    @(negedge clock);
    reset = 1'b0;
    model_clear();
    seen = 0;
    repeat (80) begin
      @(posedge clock);
      #1;
      if (bus.finished_op) seen = 1;
    end
    check("aborted init no finish", seen, 0);
    model(3, 0, 0, eo, ee, el);
    run_op("post reset count0", 3, 0, 0, eo, ee, el);
    model(0, 0, 0, eo, ee, el);
    run_op("fresh init", 0, 0, 0, eo, ee, el);

    for (int i = 0; i < 150; i++) begin
      op = ($urandom_range(0, 24) == 0) ? 0 : int'($urandom_range(1, 3));
      a1 = int'($urandom_range(0, 1023));
      a2 = int'($urandom_range(0, 1023));
      model(op, a1, a2, eo, ee, el);
      run_op($sformatf("rand%0d op%0d %0d->%0d", i, op, a1 % 4, a2 % 4),
             op, a1, a2, eo, ee, el);
    end

    for (int l = 0; l < 4; l++) begin
      model(3, l, 0, eo, ee, el);
      run_op($sformatf("final count%0d", l), 3, l, 0, eo, ee, el);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
